// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the MIPS32 fetch stage.
// Each cycle it picks the PC source by fixed priority: reset, exception,
// exception return, stall, jump, branch, sequential.
// Taken jumps and branches go through a branch-delay slot: the instruction
// after the jump or branch is fetched first, then the PC is redirected.
// The EPC is captured on an exception and restored on ERET.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   stall         in   hold PC and all state this cycle
//   jump_req      in   jump decoded at current pc
//   jump_target   in   jump destination
//   branch_req    in   taken branch at current pc
//   branch_target in   branch destination
//   exc_req       in   exception at current pc (ignores stall)
//   eret_req      in   return from exception (ignores stall)
//   pc            out  current fetch address
//   delay_slot    out  pc is a branch-delay-slot instruction
//   epc           out  exception program counter
//   exc_bd        out  last exception was taken in a delay slot
//   bds_err       out  one-cycle pulse: jump/branch ignored in a delay slot
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned PC_INC       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  input  logic        eret_req,
  output logic [31:0] pc,
  output logic        delay_slot,
  output logic [31:0] epc,
  output logic        exc_bd,
  output logic        bds_err
);

  localparam int unsigned PC_W = 32;

  typedef enum logic {
    SEQ   = 1'b0,
    DELAY = 1'b1
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_target;
  logic              r_delay_slot;
  logic [PC_W-1:0]   r_epc;
  logic              r_exc_bd;
  logic              r_bds_err;

  state_t            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [PC_W-1:0]   w_target_nxt;
  logic              w_delay_slot_nxt;
  logic [PC_W-1:0]   w_epc_nxt;
  logic              w_exc_bd_nxt;
  logic              w_bds_err_nxt;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_dec;

  // Modular increment/decrement; wrap-around at 2^32 is intended.
  assign w_pc_inc = r_pc + PC_W'(PC_INC);
  assign w_pc_dec = r_pc - PC_W'(PC_INC);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEQ;
      r_pc         <= RESET_VECTOR;
      r_target     <= '0;
      r_delay_slot <= 1'b0;
      r_epc        <= '0;
      r_exc_bd     <= 1'b0;
      r_bds_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_target     <= w_target_nxt;
      r_delay_slot <= w_delay_slot_nxt;
      r_epc        <= w_epc_nxt;
      r_exc_bd     <= w_exc_bd_nxt;
      r_bds_err    <= w_bds_err_nxt;
    end
  end

  // Next-state logic: priority exception > eret > stall > state action.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_target_nxt     = r_target;
    w_delay_slot_nxt = r_delay_slot;
    w_epc_nxt        = r_epc;
    w_exc_bd_nxt     = r_exc_bd;
    w_bds_err_nxt    = 1'b0;

    if (exc_req) begin
      w_state_nxt      = SEQ;
      w_pc_nxt         = EXC_VECTOR;
      w_target_nxt     = '0;
      w_delay_slot_nxt = 1'b0;
      // In a delay slot the restart point is the branch itself.
      if (r_state == DELAY) begin
        w_epc_nxt    = w_pc_dec;
        w_exc_bd_nxt = 1'b1;
      end else begin
        w_epc_nxt    = r_pc;
        w_exc_bd_nxt = 1'b0;
      end
    end else if (eret_req) begin
      w_state_nxt      = SEQ;
      w_pc_nxt         = r_epc;
      w_target_nxt     = '0;
      w_delay_slot_nxt = 1'b0;
    end else if (!stall) begin
      unique case (r_state)
        SEQ: begin
          if (jump_req) begin
            w_target_nxt     = jump_target;
            w_pc_nxt         = w_pc_inc;
            w_state_nxt      = DELAY;
            w_delay_slot_nxt = 1'b1;
          end else if (branch_req) begin
            w_target_nxt     = branch_target;
            w_pc_nxt         = w_pc_inc;
            w_state_nxt      = DELAY;
            w_delay_slot_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
        DELAY: begin
          // Redirect; a nested jump/branch in the delay slot is dropped.
          w_pc_nxt         = r_target;
          w_state_nxt      = SEQ;
          w_delay_slot_nxt = 1'b0;
          w_bds_err_nxt    = jump_req | branch_req;
        end
        default: begin
          w_state_nxt = SEQ;
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign delay_slot = r_delay_slot;
  assign epc        = r_epc;
  assign exc_bd     = r_exc_bd;
  assign bds_err    = r_bds_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random
// traffic, checked against a behavioural model of the fetch PC.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump_req;
  logic [31:0] jump_target;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] pc;
  logic        delay_slot;
  logic [31:0] epc;
  logic        exc_bd;
  logic        bds_err;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (32'h0000_0080),
    .PC_INC      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump_req     (jump_req),
    .jump_target  (jump_target),
    .branch_req   (branch_req),
    .branch_target(branch_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .pc           (pc),
    .delay_slot   (delay_slot),
    .epc          (epc),
    .exc_bd       (exc_bd),
    .bds_err      (bds_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        ds;
    logic [31:0] epc;
    logic        bd;
    logic        bds;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  // Reference model: the fetch PC, an optional pending redirect, and EPC.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_bd;
  bit          m_pending;
  logic [31:0] m_pending_tgt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic drive(input bit r, input bit st, input bit j, input logic [31:0] jt,
                       input bit b, input logic [31:0] bt, input bit ex, input bit er);
    exp_t e;
    bit   err;
    @(negedge clk);
    rst = r; stall = st; jump_req = j; jump_target = jt;
    branch_req = b; branch_target = bt; exc_req = ex; eret_req = er;
    err = 0;
    if (r) begin
      m_pc = 32'h0; m_epc = 32'h0; m_bd = 0; m_pending = 0;
    end else if (ex) begin
      // The faulting instruction of a delay slot is the preceding branch.
      m_epc = m_pending ? m_pc - 32'd4 : m_pc;
      m_bd  = m_pending;
      m_pc  = 32'h80;
      m_pending = 0;
    end else if (er) begin
      m_pc = m_epc;
      m_pending = 0;
    end else if (st) begin
      // nothing moves
    end else if (m_pending) begin
      m_pc = m_pending_tgt;
      m_pending = 0;
      err = j || b;
    end else if (j || b) begin
      m_pending_tgt = j ? jt : bt;
      m_pending = 1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.ds = m_pending; e.epc = m_epc; e.bd = m_bd; e.bds = err;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, so pop one prediction per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", pc, e.pc);
        check("delay_slot", 32'(delay_slot), 32'(e.ds));
        check("epc", epc, e.epc);
        check("exc_bd", 32'(exc_bd), 32'(e.bd));
        check("bds_err", 32'(bds_err), 32'(e.bds));
      end
    end
  end

  initial begin
    logic [31:0] t;
    int          w;
    rst = 1; stall = 0; jump_req = 0; jump_target = 0; branch_req = 0;
    branch_target = 0; exc_req = 0; eret_req = 0;
    m_pc = 0; m_epc = 0; m_bd = 0; m_pending = 0; m_pending_tgt = 0;

    // Reset, sequential fetch, jump+branch together, branch in delay slot.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 32'd200, 1, 32'd300, 0, 0);
    drive(0, 0, 0, 0, 1, 32'd300, 0, 0);
    idle(1);

    // Stall in the delay slot.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 32'd200, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Exception in delay slot, ERET, exception in SEQ, exc+eret together.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 32'd200, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 1);

    // Wrap-around through 0xFFFF_FFFC.
    drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
    idle(4);

    // Reset while stalled in the delay slot drops the pending target.
    drive(0, 0, 0, 0, 1, 32'd500, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      t = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00}
                                    : {$urandom_range(0, 32'h3FFF), 2'b00};
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 20, t,
            $urandom_range(0, 99) < 20, {$urandom_range(0, 32'h3FFF), 2'b00},
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
    end
    idle(1);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    done = 1;
    $finish;
  end

endmodule
